ring_nic: RTL

Network interface controller that sits between a processing element (PE) and the PE port of one ring router. It is the far end of the router's PE channel pair (pesi/peri/pedi into the router, peso/pero/pedo out of it). It exposes a 4-word register map to the processor and two single-entry 64-bit channel buffers to the router. It injects processor-written packets only on the router's matching polarity and accepts ejected packets whenever its input buffer is empty.

---
 rtl/ring_nic_pkg.sv | 20 ++
 rtl/ring_nic_if.sv | 37 +++
 rtl/ring_nic_chan_buf.sv | 70 +++++++
 rtl/ring_nic.sv | 79 +++++++
 4 files changed

// File: rtl/ring_nic_pkg.sv
// ring_nic_pkg
// Shared constants and types for the ring NIC: packet geometry, the
// processor register map and the two-state channel buffer encoding.
package ring_nic_pkg;

    localparam int PKT_W  = 64;   // packet width
    localparam int ADDR_W = 2;    // processor register address width
    localparam int VC_BIT = 63;   // virtual-channel bit inside a packet

    localparam logic [ADDR_W-1:0] ADDR_IN_BUF   = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_IN_STAT  = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_OUT_BUF  = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_OUT_STAT = 2'd3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_e;

endpackage

// File: rtl/ring_nic_if.sv
// ring_nic_if
// Bundles the processor register bus and the router PE channel pair of the
// ring NIC.
//   Processor side : nicEn, nicWrEn, addr, d_in (to NIC), d_out (from NIC)
//   Router side    : net_polarity, net_ro, net_si, net_di (to NIC),
//                    net_so, net_do, net_ri (from NIC)
// The slave modport is the NIC's view; master is the PE/router environment.
interface ring_nic_if;
    import ring_nic_pkg::*;

    logic              nicEn;
    logic              nicWrEn;
    logic [ADDR_W-1:0] addr;
    logic [PKT_W-1:0]  d_in;
    logic [PKT_W-1:0]  d_out;

    logic              net_polarity;
    logic              net_so;
    logic              net_ro;
    logic [PKT_W-1:0]  net_do;
    logic              net_si;
    logic              net_ri;
    logic [PKT_W-1:0]  net_di;

    modport slave (
        input  nicEn, nicWrEn, addr, d_in,
        input  net_polarity, net_ro, net_si, net_di,
        output d_out, net_so, net_do, net_ri
    );

    modport master (
        output nicEn, nicWrEn, addr, d_in,
        output net_polarity, net_ro, net_si, net_di,
        input  d_out, net_so, net_do, net_ri
    );

endinterface

// File: rtl/ring_nic_chan_buf.sv
// nic_chan_buf
// Single-entry packet buffer with an EMPTY/FULL state machine.
//   clk, reset : clock, synchronous active-low reset
//   i_load     : offer i_data; accepted only while EMPTY
//   i_unload   : drain the entry; honoured only while FULL
//   i_data     : data to load
//   o_full     : buffer holds a packet
//   o_data     : stored packet (keeps its last value after an unload)
module nic_chan_buf
    import ring_nic_pkg::*;
#(
    parameter int W = PKT_W
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_unload,
    input  logic [W-1:0] i_data,
    output logic         o_full,
    output logic [W-1:0] o_data
);

    chan_state_e  r_state;
    chan_state_e  w_next;
    logic         w_load_acc;
    logic [W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data <= '0;
        end else if (w_load_acc) begin
            r_data <= i_data;
        end
    end

    // Load and unload are mutually exclusive by state, so a drained entry
    // cannot be refilled in the same cycle.
    always_comb begin
        w_next     = r_state;
        w_load_acc = 1'b0;
        case (r_state)
            EMPTY: begin
                if (i_load) begin
                    w_load_acc = 1'b1;
                    w_next     = FULL;
                end
            end
            FULL: begin
                if (i_unload) begin
                    w_next = EMPTY;
                end
            end
        endcase
    end

    always_comb begin
        o_full = (r_state == FULL);
        o_data = r_data;
    end

endmodule

// File: rtl/ring_nic.sv
// ring_nic
// Network interface between a processing element and one ring router PE
// port. Processor writes to the output buffer are injected on the router's
// matching polarity; router ejections land in the input buffer whenever it
// is empty and are drained by processor reads.
//   clk   : clock
//   reset : synchronous active-low reset
//   bus   : ring_nic_if.slave (processor register bus + router channels)
module ring_nic
    import ring_nic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    ring_nic_if.slave  bus
);

    logic             w_rd;
    logic             w_wr;
    logic             w_out_load;
    logic             w_out_full;
    logic [PKT_W-1:0] w_out_data;
    logic             w_send;
    logic             w_in_load;
    logic             w_in_unload;
    logic             w_in_full;
    logic [PKT_W-1:0] w_in_data;
    logic [PKT_W-1:0] w_dout;

    assign w_rd = bus.nicEn & ~bus.nicWrEn;
    assign w_wr = bus.nicEn &  bus.nicWrEn;

    assign w_out_load  = w_wr & (bus.addr == ADDR_OUT_BUF);
    assign w_in_unload = w_rd & (bus.addr == ADDR_IN_BUF);

    // A packet may only enter the ring on the cycle whose polarity matches
    // its VC bit; a reset cycle never sends because the buffer is discarded.
    assign w_send = reset & w_out_full & bus.net_ro &
                    (w_out_data[VC_BIT] == bus.net_polarity);

    assign w_in_load = bus.net_si & ~w_in_full;

    nic_chan_buf #(.W(PKT_W)) u_out_buf (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_out_load),
        .i_unload (w_send),
        .i_data   (bus.d_in),
        .o_full   (w_out_full),
        .o_data   (w_out_data)
    );

    nic_chan_buf #(.W(PKT_W)) u_in_buf (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_in_load),
        .i_unload (w_in_unload),
        .i_data   (bus.net_di),
        .o_full   (w_in_full),
        .o_data   (w_in_data)
    );

    always_comb begin
        w_dout = '0;
        if (w_rd) begin
            case (bus.addr)
                ADDR_IN_BUF:   w_dout = w_in_data;
                ADDR_IN_STAT:  w_dout = {{(PKT_W-1){1'b0}}, w_in_full};
                ADDR_OUT_STAT: w_dout = {{(PKT_W-1){1'b0}}, w_out_full};
                default:       w_dout = '0;
            endcase
        end
    end

    assign bus.d_out  = w_dout;
    assign bus.net_so = w_send;
    assign bus.net_do = w_out_data;
    assign bus.net_ri = ~w_in_full;

endmodule
